// File: rtl/morph_iterate_if.sv
// Handshake and image bus for morph_iterate. The requester drives the
// request fields; the morphology engine returns the work image together
// with busy/done status.
interface morph_iterate_if #(
    parameter int Width     = 8,
    parameter int Height    = 4,
    parameter int IterWidth = 4
);
    logic                      start;
    logic [1:0]                mode;
    logic [IterWidth-1:0]      iterations;
    logic [8:0]                mask;
    logic [Width*Height-1:0]   imageIn;
    logic [Width*Height-1:0]   imageOut;
    logic                      busy;
    logic                      done;

    modport master (
        output start, mode, iterations, mask, imageIn,
        input  imageOut, busy, done
    );

    modport slave (
        input  start, mode, iterations, mask, imageIn,
        output imageOut, busy, done
    );
endinterface

// File: rtl/morph_iterate.sv
// Iterative 3x3 binary morphology engine. A whole-frame binary image is
// held in a work register and one dilate or erode pass is applied to the
// full frame per clock. Open and close run two phases of N passes each.
module morph_iterate #(
    parameter int Width     = 8,
    parameter int Height    = 4,
    parameter int IterWidth = 4
) (
    input  logic            clock,
    input  logic            reset,
    morph_iterate_if.slave  bus
);
    localparam int NPix = Width * Height;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_A = 2'd1,
        RUN_B = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [IterWidth-1:0]  cnt_r;
    logic [IterWidth-1:0]  cnt_next_s;
    logic [IterWidth-1:0]  n_r;
    logic [1:0]            mode_r;
    logic [8:0]            mask_r;
    logic [NPix-1:0]       image_r;
    logic [NPix-1:0]       image_next_s;
    logic                  busy_r;
    logic                  busy_next_s;
    logic                  done_r;
    logic                  done_next_s;
    logic                  latch_s;
    logic                  phase_erode_s;
    logic                  mode_two_phase_s;
    logic [NPix-1:0]       pass_s;

    // One full-frame pass. Out-of-frame neighbours read as the identity of
    // the reduction (0 for OR, 1 for AND) so frame edges never erode.
    function automatic logic [NPix-1:0] morph_pass(
        input logic [NPix-1:0] img,
        input logic [8:0]      m,
        input logic            erode
    );
        logic [NPix-1:0] res;
        logic            acc;
        logic            nb;
        int              rr;
        int              cc;
        res = '0;
        for (int r = 0; r < Height; r++) begin
            for (int c = 0; c < Width; c++) begin
                acc = erode;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (rr < 0 || rr >= Height || cc < 0 || cc >= Width) begin
                            nb = erode;
                        end else begin
                            nb = img[(Height-1-rr)*Width + (Width-1-cc)];
                        end
                        // mask[8] is top-left, mask[4] centre, mask[0] bottom-right
                        if (m[8 - ((dr+1)*3 + (dc+1))]) begin
                            if (erode) begin
                                acc = acc & nb;
                            end else begin
                                acc = acc | nb;
                            end
                        end else begin
                            acc = acc;
                        end
                    end
                end
                res[(Height-1-r)*Width + (Width-1-c)] = acc;
            end
        end
        return res;
    endfunction

    // Select the operator for the current phase: phase A erodes for erode
    // and open, phase B always applies the opposite operator.
    always_comb begin
        phase_erode_s    = 1'b0;
        mode_two_phase_s = 1'b0;
        case (mode_r)
            2'd0:    begin phase_erode_s = 1'b0; mode_two_phase_s = 1'b0; end
            2'd1:    begin phase_erode_s = 1'b1; mode_two_phase_s = 1'b0; end
            2'd2:    begin phase_erode_s = 1'b1; mode_two_phase_s = 1'b1; end
            2'd3:    begin phase_erode_s = 1'b0; mode_two_phase_s = 1'b1; end
            default: begin phase_erode_s = 1'b0; mode_two_phase_s = 1'b0; end
        endcase
        if (state_r == RUN_B) begin
            phase_erode_s = ~phase_erode_s;
        end else begin
            phase_erode_s = phase_erode_s;
        end
    end

    // Purely combinational pass over the current work register.
    always_comb begin
        pass_s = morph_pass(image_r, mask_r, phase_erode_s);
    end

    // Next-state and next-output logic for the pass sequencer.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        image_next_s = image_r;
        busy_next_s  = busy_r;
        done_next_s  = 1'b0;
        latch_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    latch_s      = 1'b1;
                    image_next_s = bus.imageIn;
                    busy_next_s  = 1'b1;
                    cnt_next_s   = bus.iterations;
                    if (bus.iterations == {IterWidth{1'b0}}) begin
                        state_next_s = FLUSH;
                    end else begin
                        state_next_s = RUN_A;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN_A: begin
                image_next_s = pass_s;
                if (cnt_r == IterWidth'(1)) begin
                    if (mode_two_phase_s) begin
                        cnt_next_s   = n_r;
                        state_next_s = RUN_B;
                    end else begin
                        state_next_s = IDLE;
                        done_next_s  = 1'b1;
                        busy_next_s  = 1'b0;
                    end
                end else begin
                    cnt_next_s = cnt_r - IterWidth'(1);
                end
            end
            RUN_B: begin
                image_next_s = pass_s;
                if (cnt_r == IterWidth'(1)) begin
                    state_next_s = IDLE;
                    done_next_s  = 1'b1;
                    busy_next_s  = 1'b0;
                end else begin
                    cnt_next_s = cnt_r - IterWidth'(1);
                end
            end
            FLUSH: begin
                state_next_s = IDLE;
                done_next_s  = 1'b1;
                busy_next_s  = 1'b0;
            end
            default: begin
                state_next_s = IDLE;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // State, counter, work image and status registers; reset discards any
    // partial result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {IterWidth{1'b0}};
            image_r <= {NPix{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            image_r <= image_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Operation settings latched at start so they stay fixed for the run.
    always_ff @(posedge clock) begin
        if (reset) begin
            n_r    <= {IterWidth{1'b0}};
            mode_r <= 2'd0;
            mask_r <= 9'd0;
        end else if (latch_s) begin
            n_r    <= bus.iterations;
            mode_r <= bus.mode;
            mask_r <= bus.mask;
        end else begin
            n_r    <= n_r;
            mode_r <= mode_r;
            mask_r <= mask_r;
        end
    end

    assign bus.imageOut = image_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_morph_iterate.sv
// Self-checking bench for morph_iterate: directed cases with hand-derived
// images plus randomized operations checked against a 2-D array model.
module tb_morph_iterate;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int IW = 4;
    localparam int NP = W * H;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    morph_iterate_if #(.Width(W), .Height(H), .IterWidth(IW)) bus ();

    morph_iterate #(.Width(W), .Height(H), .IterWidth(IW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: one pass on a 2-D pixel grid, counting hits in the window.
    function automatic logic [NP-1:0] ref_pass(input logic [NP-1:0] img, input logic [8:0] m, input bit erode);
        bit px [H][W];
        bit se [3][3];
        logic [NP-1:0] res;
        int total;
        int hits;
        bit v;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                px[r][c] = img[(H-1-r)*W + (W-1-c)];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                se[i][j] = m[8 - 3*i - j];
        res = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                total = 0;
                hits  = 0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        if (se[i][j]) begin
                            total++;
                            if (r+i-1 < 0 || r+i-1 >= H || c+j-1 < 0 || c+j-1 >= W) v = erode;
                            else v = px[r+i-1][c+j-1];
                            hits += int'(v);
                        end
                    end
                end
                res[(H-1-r)*W + (W-1-c)] = erode ? (hits == total) : (hits > 0);
            end
        end
        return res;
    endfunction

    function automatic logic [NP-1:0] ref_run(input logic [1:0] md, input int n, input logic [8:0] m, input logic [NP-1:0] img);
        logic [NP-1:0] cur;
        bit first_erode;
        cur = img;
        first_erode = (md == 2'd1) || (md == 2'd2);
        for (int k = 0; k < n; k++) cur = ref_pass(cur, m, first_erode);
        if (md >= 2'd2)
            for (int k = 0; k < n; k++) cur = ref_pass(cur, m, !first_erode);
        return cur;
    endfunction

    function automatic int ref_lat(input logic [1:0] md, input int n);
        if (n == 0) return 1;
        return (md >= 2'd2) ? 2*n : n;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [1:0] md, input int n, input logic [8:0] m, input logic [NP-1:0] img);
        logic [31:0] nv;
        nv = n;
        bus.mode       = md;
        bus.iterations = nv[IW-1:0];
        bus.mask       = m;
        bus.imageIn    = img;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("busy_after_start", {63'd0, bus.busy}, 64'd1);
    endtask

    // Waits for done (bounded) and checks latency, busy and the result.
    task automatic wait_done(input string tag, input int lat0, input int exp_lat, input logic [NP-1:0] exp_img);
        int lat;
        lat = lat0;
        while (!bus.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_img"}, 64'(bus.imageOut), 64'(exp_img));
        check_val({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
    endtask

    localparam logic [8:0] CROSS = 9'b010_111_010;

    initial begin
        logic [NP-1:0] img;
        logic [NP-1:0] alt;
        logic [8:0]    m;
        logic [1:0]    md;
        int            n;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.mode = 2'd0;
        bus.iterations = '0;
        bus.mask = 9'd0;
        bus.imageIn = '0;
        repeat (3) @(negedge clk);
        check_val("reset_busy", {63'd0, bus.busy}, 64'd0);
        check_val("reset_done", {63'd0, bus.done}, 64'd0);
        check_val("reset_img", 64'(bus.imageOut), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with hand-derived results.
        launch(2'd0, 1, CROSS, 32'h0008_1000);
        wait_done("dilate1", 0, 1, 32'h081C_3810);
        @(negedge clk);
        check_val("done_pulse", {63'd0, bus.done}, 64'd0);
        check_val("hold_img", 64'(bus.imageOut), 64'h081C_3810);

        launch(2'd3, 1, CROSS, 32'h0008_1000);
        wait_done("close1", 0, 2, 32'h0008_1000);

        launch(2'd0, 2, CROSS, 32'h0008_0000);
        wait_done("dilate2", 0, 2, 32'h1C3E_1C08);

        launch(2'd2, 1, CROSS, 32'h0008_0000);
        wait_done("open1", 0, 2, 32'h0000_0000);

        launch(2'd1, 3, CROSS, 32'hFFFF_FFFF);
        wait_done("erode_border", 0, 3, 32'hFFFF_FFFF);

        for (int md_i = 0; md_i < 4; md_i++) begin
            launch(2'(md_i), 0, CROSS, 32'hA5C3_0F96);
            wait_done("flush", 0, 1, 32'hA5C3_0F96);
        end

        launch(2'd1, 1, 9'd0, 32'h1234_0000);
        wait_done("mask0_erode", 0, 1, 32'hFFFF_FFFF);

        // Start during a run must be ignored.
        img = $urandom() | $urandom();
        launch(2'd1, 15, 9'b111_111_111, img);
        @(negedge clk);
        bus.start = 1'b1;
        bus.imageIn = ~img;
        bus.mode = 2'd0;
        bus.iterations = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignore_start", 2, 15, ref_run(2'd1, 15, 9'b111_111_111, img));

        // Reset mid-run, then a normal run.
        launch(2'd1, 15, CROSS, $urandom());
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midreset_busy", {63'd0, bus.busy}, 64'd0);
        check_val("midreset_done", {63'd0, bus.done}, 64'd0);
        check_val("midreset_img", 64'(bus.imageOut), 64'd0);
        img = $urandom();
        launch(2'd3, 2, CROSS, img);
        wait_done("after_reset", 0, 4, ref_run(2'd3, 2, CROSS, img));

        // Start on the done cycle is accepted.
        alt = $urandom();
        launch(2'd0, 1, CROSS, alt);
        wait_done("b2b_first", 0, 1, ref_run(2'd0, 1, CROSS, alt));

        // Randomized operations, alternating back-to-back and idle gaps.
        for (int i = 0; i < 24; i++) begin
            md  = 2'($urandom_range(0, 3));
            n   = $urandom_range(0, 5);
            m   = 9'($urandom());
            img = (i % 3 == 0) ? ($urandom() & $urandom()) : $urandom();
            if (i % 2 == 1) begin
                @(negedge clk);
                check_val("rnd_done_low", {63'd0, bus.done}, 64'd0);
            end
            launch(md, n, m, img);
            wait_done("rnd", 0, ref_lat(md, n), ref_run(md, n, m, img));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/morph_iterate.md
Name: morph_iterate

Overview:
- Sequential, parametrised successor to the combinational single-pass `Dilate` block.
- Applies a 3x3 binary morphology operator repeatedly to a whole-frame binary image held in a work register, one full-frame pass per clock.
- Supports four modes: dilate, erode, open and close, each with a programmable iteration count.
- Sits between binary thresholding and blob/feature logic. Uses a start/busy/done handshake.

Parameters:
- `Width`, default 8: image columns.
- `Height`, default 4: image rows.
- `IterWidth`, default 4: width of the iteration-count input. Maximum N = 2^IterWidth-1.

Ports:
- `clock`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request; sampled only when `busy`=0.
- `mode`, in, 2: 0=dilate, 1=erode, 2=open (erode N then dilate N), 3=close (dilate N then erode N).
- `iterations`, in, `IterWidth`: N, the passes per phase.
- `mask`, in, 9: structuring element. [8:6] top row, [5:3] middle row, [2:0] bottom row. Within each row the MSB is the left column; `mask[4]` is the centre.
- `imageIn`, in, `Width*Height`: pixel (r,c), with r=0 the top row and c=0 the left column, is at bit (Height-1-r)*Width+(Width-1-c).
- `imageOut`, out, `Width*Height`: work register, same bit layout as `imageIn`.
- `busy`, out, 1: high from the accepting edge until the result is written.
- `done`, out, 1: one-cycle pulse when `imageOut` holds the final result.

Behaviour:
- **Reset** (synchronous, active-high): state=IDLE, `imageOut`=0, `busy`=0, `done`=0. Reset overrides everything, including mid-operation; the partial result is discarded.
- **States:** IDLE, RUN_A, RUN_B, FLUSH.
- **Start accept** (IDLE, `start`=1 at edge k):
  - Capture `imageIn` into the work register; latch `mask`, `mode` and N.
  - `busy`<=1.
  - Next state: FLUSH if N=0, else RUN_A with counter=N.
  - `start` is ignored while `busy`=1; latched inputs do not change mid-operation.
- **RUN_A:** each edge applies the phase-A operator (dilate for modes 0 and 3, erode for modes 1 and 2) and decrements the counter. On the last pass:
  - Modes 0 and 1: go to IDLE, `done`<=1, `busy`<=0.
  - Modes 2 and 3: reload counter=N and go to RUN_B.
- **RUN_B:** applies the opposite operator N times. On the last pass: go to IDLE, `done`<=1, `busy`<=0.
- **FLUSH** (N=0): one edge with no operator applied, then go to IDLE with `done`<=1. Result = `imageIn` unchanged, for every mode.
- **Latency:** P = N for modes 0/1, P = 2N for modes 2/3. `done` is high in the cycle after edge k+max(P,1).
- **Output hold:** `imageOut` holds the result until the next accepted start. `done` is high for exactly one cycle.
- **Start on the done cycle:** a start in the cycle where `done`=1 is accepted, since the FSM is in IDLE. Back-to-back operations are allowed.
- **Dilate:** out(r,c) = OR, over set mask bits (dr,dc in -1..1), of in(r+dr,c+dc). Out-of-frame pixels read as 0.
- **Erode:** out(r,c) = AND, over set mask bits, of in(r+dr,c+dc). Out-of-frame pixels read as 1, so frame edges do not erode.
- **Mask edge cases:**
  - Mask=0: dilate gives all 0; erode gives all 1.
  - Centre bit clear: the pixel itself is excluded from its own neighbourhood.
- **Implementation:** the per-pass operator is purely combinational from the work register. No inter-pass pipelining.

Test Plan:
- **Dilate, N=1.** Input: `Width`=8, `Height`=4, rows 00000000/00001000/00010000/00000000, mask 010/111/010, mode 0, start. Required: `done` 1 cycle after the start edge; `imageOut` rows 00001000/00011100/00111000/00010000; `busy` high for exactly that cycle.
- **Close, N=1.** Same image and mask, mode 3. Required: `done` after 2 cycles; `imageOut` equals the input rows 00000000/00001000/00010000/00000000.
- **Dilate, N=2.** Single pixel at (1,4), cross mask, mode 0. Required: `done` after 2 cycles; rows 00011100/00111110/00011100/00001000.
- **Open / erode borders.**
  - Open, N=1, cross mask, single pixel at (1,4): required `imageOut`=0 after 2 cycles.
  - Erode, N=3, cross mask, all-ones image: required all-ones after 3 cycles (border rule).
- **Passthrough / empty mask.**
  - N=0, any mode: required `done` after 1 cycle with `imageOut`=`imageIn`.
  - Mask=0, erode, N=1: required all-ones output.
- **Handshake / reset.**
  - Erode, N=15: a `start` with different `imageIn` pulsed mid-run is ignored; the result matches the undisturbed run; `done` arrives after 15 cycles.
  - Rerun, asserting `reset` at cycle 5: next cycle `busy`=0, `done`=0, `imageOut`=0. A following start behaves normally.
  - Start asserted on the `done` cycle: accepted.
